// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential packed-BCD adder/subtractor.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t nines_comp(bcd_t v);
        return BCD_MAX - v;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of add with +6 correction; combinational.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_t x,
    input  bcd_t y,
    input  logic c,
    output bcd_t d,
    output logic co
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        if (t > {1'b0, BCD_MAX}) begin
            d  = t[3:0] + 4'd6;
            co = 1'b1;
        end else begin
            d  = t[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, one digit cell shared across DIGITS cycles.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   s,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            sub_q, sub_d, carry_q, carry_d, bad_q, bad_d;
    logic            cout_q, cout_d, err_q, err_d;

    logic            bad_in;
    bcd_t            cell_y, cell_d;
    logic            cell_co;
    logic [W-1:0]    acc_next;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) bad_in = 1'b1;
        end
    end

    assign cell_y = sub_q ? nines_comp(b_q[3:0]) : b_q[3:0];

    bcd_digit_cell u_cell (
        .x  (a_q[3:0]),
        .y  (cell_y),
        .c  (carry_q),
        .d  (cell_d),
        .co (cell_co)
    );

    // Result digits enter at the top so digit 0 lands at the bottom after DIGITS shifts.
    assign acc_next = (acc_q >> 4) | (W'(cell_d) << (W - 4));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        bad_d   = bad_q;
        s_d     = s_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    // Ten's-complement +1 and the borrow-in cancel, hence ~cin.
                    carry_d = sub ? ~cin : cin;
                    bad_d   = bad_in;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                acc_d   = acc_next;
                carry_d = cell_co;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == IdxW'(DIGITS - 1)) begin
                    state_d = StDone;
                    s_d     = bad_q ? '0 : acc_next;
                    cout_d  = bad_q ? 1'b0 : cell_co;
                    err_d   = bad_q;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            bad_q   <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            bad_q   <= bad_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign s         = s_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed self-checking bench for bcd_seq_adder with DIGITS=4.
module tb_bcd_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, s;
    logic        cin, sub, cout, err;

    int n_checks = 0;
    int n_errors = 0;

    bcd_seq_adder #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, check latency and result, hold out_ready low for 'hold' cycles, then retire it.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb, input logic [15:0] es,
                          input logic ec, input logic ee, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = av; b = bv; cin = ci; sub = sb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_err"}, 32'(err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_s"}, 32'(s), 32'(es));
            check({tag, "_hold_cout"}, 32'(cout), 32'(ec));
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ret_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ret_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_s"}, 32'(s), 32'(es));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 0);
        run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("add_9999_9999_c", 16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 0);
        run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0, 0);
        run_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 0);
        run_op("sub_0100_0099_b", 16'h0100, 16'h0099, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        run_op("err_12A4", 16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 0);
        run_op("after_err", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
        run_op("backpressure", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 5);

        // Reset during the second RUN cycle discards the op.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h9999; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_in_ready", 32'(in_ready), 32'd1);
        check("midrun_out_valid", 32'(out_valid), 32'd0);
        check("midrun_s", 32'(s), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrun_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("post_rst_0001_0001", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_seq_adder.md
# bcd_seq_adder

Multi-digit packed-BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, through a single digit cell. It is the parametrised successor of our single-digit combinational BCD adder. It adds an operand-width parameter, a subtract mode, invalid-digit detection and valid/ready handshakes on both sides. It sits between operand registers and a display or accumulator stage, where area matters more than throughput.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand and result (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept an operation
- a  in  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]
- b  in  4*DIGITS  packed BCD operand
- cin  in  1  add mode: carry-in; sub mode: borrow-in
- sub  in  1  0 = a+b+cin, 1 = a−b−cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  4*DIGITS  packed BCD result
- cout  out  1  add mode: carry-out; sub mode: 1 = no borrow (a ≥ b+cin)
- err  out  1  an operand nibble was >9

## Operation
- FSM states:
  - IDLE: in_ready=1. in_valid&&in_ready captures a, b, sub and the initial carry, clears the digit index, then goes to RUN.
  - RUN: each cycle processes the digit at the current index and increments it. After the edge that processes digit DIGITS−1, goes to DONE.
  - DONE: out_valid=1. On out_ready goes to IDLE.
- Initial carry: add mode uses cin. Sub mode uses ~cin, because the ten's-complement +1 is cancelled by the borrow.
- Operand b per digit:
  - add mode: b digit unchanged.
  - sub mode: nine's complement, 9−b digit.
- Digit cell: t = a_d + b_d' + c (5-bit). If t>9, the digit is t+6 (low 4 bits) and the carry-out is 1. Otherwise the digit is t and the carry-out is 0.
- cout is the carry out of digit DIGITS−1.
- Sub-mode negative results stay in ten's-complement form, e.g. 0000−0001 = 9999 with cout=0.
- err is evaluated on all nibbles of a and b at capture:
  - If set, the operation still runs the full RUN sequence.
  - The delivered s is forced to 0, cout to 0, and err=1.
- s, cout and err are updated only on the DONE transition. They hold until the next DONE, so they stay stable in IDLE.

## Timing
- Reset values:
  - state IDLE, in_ready=1, out_valid=0
  - s=0, cout=0, err=0, index=0
- Reset mid-RUN or mid-DONE returns to IDLE on the next edge. The in-flight operation is discarded and no out_valid is issued.
- Latency: out_valid rises DIGITS cycles after the accepting edge.
- in_ready is 0 in RUN and DONE. No acceptance overlaps an in-flight operation.
- Best-case initiation interval is DIGITS+2 cycles: accept, DIGITS RUN cycles, DONE with out_ready=1.
- out_valid holds until out_ready. s, cout and err are stable throughout the wait.
- out_ready sampled in IDLE or RUN has no effect.
- a, b, sub and cin may change freely after acceptance; the captured copies are used.
- DIGITS=1: one RUN cycle, identical arithmetic.

## Structure
- bcd_pkg holds:
  - typedef bcd_t (logic [3:0])
  - FSM state enum (IDLE, RUN, DONE)
  - constant BCD_MAX = 9
  - function nines_comp(bcd_t)
- Sub-module bcd_digit_cell: combinational digit add with decimal correction.
  - inputs: bcd_t x, y, carry c
  - outputs: bcd_t d, carry co
- Top level holds the FSM, operand shift registers, the carry flop and the result register.

## Test plan
Scenarios use DIGITS=4.
- 1234+5678, cin=0, sub=0 -> s=6912, cout=0, err=0; out_valid exactly 4 cycles after accept.
- 9999+0001, cin=0 -> s=0000, cout=1. 9999+9999, cin=1 -> s=9999, cout=1.
- sub: 5000−1234, cin=0 -> 3766, cout=1. 0000−0001 -> 9999, cout=0. 0100−0099, cin=1 -> 0000, cout=1.
- a=12A4 (nibble 0xA) + 0001 -> err=1, s=0000, cout=0. The following valid op clears err.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid, s and cout stable, in_ready=0. Then in_ready returns the cycle after the out_ready handshake.
- rst asserted on the second RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, s=0. A fresh 0001+0001 then yields 0002.
